hazard_ctrl: RTL

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_pkg.sv | 20 ++
 rtl/hazard_ctrl_fw_sel.sv | 41 ++++
 rtl/hazard_ctrl.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// Shared types and encodings for the pipeline hazard controller.
package hazard_pkg;

   typedef enum logic [1:0] {
      ST_RUN,
      ST_BUBBLE,
      ST_MEMWAIT
   } state_e;

   localparam logic [2:0] FW_RF        = 3'd0;
   localparam logic [2:0] FW_EXMEM_ALU = 3'd1;
   localparam logic [2:0] FW_MEMWB_ALU = 3'd2;
   localparam logic [2:0] FW_MEMWB_MEM = 3'd3;
   localparam logic [2:0] FW_MEMWB_PC4 = 3'd4;

   localparam logic [1:0] WB_ALU = 2'd0;
   localparam logic [1:0] WB_MEM = 2'd1;
   localparam logic [1:0] WB_PC4 = 2'd2;

endpackage

// File: rtl/hazard_ctrl_fw_sel.sv
// Per-operand forwarding source select; EX/MEM has priority over MEM/WB.
module fw_sel
   import hazard_pkg::*;
#(
   parameter int unsigned SEL_W = 3
) (
   input  logic [4:0]       rs_addr_i,
   input  logic             mem_valid_i,
   input  logic             mem_regwrite_i,
   input  logic [4:0]       mem_rd_addr_i,
   input  logic [1:0]       mem_wb_sel_i,
   input  logic             wb_valid_i,
   input  logic             wb_regwrite_i,
   input  logic [4:0]       wb_rd_addr_i,
   input  logic [1:0]       wb_sel_i,
   output logic [SEL_W-1:0] sel_o
);

   logic mem_hit;
   logic wb_hit;

   assign mem_hit = mem_valid_i && mem_regwrite_i && (mem_rd_addr_i != 5'd0)
                    && (mem_rd_addr_i == rs_addr_i);
   assign wb_hit  = wb_valid_i && wb_regwrite_i && (wb_rd_addr_i != 5'd0)
                    && (wb_rd_addr_i == rs_addr_i);

   always_comb begin
      sel_o = SEL_W'(FW_RF);
      if (mem_hit && (mem_wb_sel_i == WB_ALU)) begin
         sel_o = SEL_W'(FW_EXMEM_ALU);
      end else if (wb_hit) begin
         case (wb_sel_i)
            WB_ALU:  sel_o = SEL_W'(FW_MEMWB_ALU);
            WB_MEM:  sel_o = SEL_W'(FW_MEMWB_MEM);
            WB_PC4:  sel_o = SEL_W'(FW_MEMWB_PC4);
            default: sel_o = SEL_W'(FW_RF);
         endcase
      end
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: operand forwarding, load-use bubbles,
// branch flushes, data-memory wait stalls and performance counters.
module hazard_ctrl
   import hazard_pkg::*;
#(
   parameter  int unsigned XLEN     = 32,
   parameter  int unsigned NUM_FW   = 4,
   parameter  int unsigned LU_STALL = 1,
   parameter  int unsigned CNT_W    = 32,
   localparam int unsigned SEL_W    = $clog2(NUM_FW + 1)
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             dec_valid_i,
   input  logic [4:0]       dec_rs1_addr_i,
   input  logic [4:0]       dec_rs2_addr_i,
   input  logic             ex_valid_i,
   input  logic [4:0]       ex_rs1_addr_i,
   input  logic [4:0]       ex_rs2_addr_i,
   input  logic [4:0]       ex_rd_addr_i,
   input  logic             ex_regwrite_i,
   input  logic [1:0]       ex_wb_sel_i,
   input  logic             mem_valid_i,
   input  logic             mem_regwrite_i,
   input  logic [4:0]       mem_rd_addr_i,
   input  logic [1:0]       mem_wb_sel_i,
   input  logic             wb_valid_i,
   input  logic             wb_regwrite_i,
   input  logic [4:0]       wb_rd_addr_i,
   input  logic [1:0]       wb_sel_i,
   input  logic             bj_sig_i,
   input  logic             dmem_busy_i,
   output logic             stall_if_o,
   output logic             flush_if_o,
   output logic             stall_id_o,
   output logic             flush_id_o,
   output logic             stall_ex_o,
   output logic             flush_ex_o,
   output logic             stall_mem_o,
   output logic             flush_mem_o,
   output logic [SEL_W-1:0] fw0_sel_o,
   output logic [SEL_W-1:0] fw1_sel_o,
   output logic [CNT_W-1:0] stall_cnt_o,
   output logic [CNT_W-1:0] flush_cnt_o
);

   if (XLEN < 1 || LU_STALL < 1 || LU_STALL > 3) begin : g_bad_param
      $error("hazard_ctrl: illegal XLEN or LU_STALL");
   end

   state_e           state_q, state_d;
   logic [1:0]       bub_q, bub_d;
   logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
   logic [SEL_W-1:0] sel0, sel1;
   logic             lu_hazard;
   logic             st_if, st_id, st_ex, st_mem, fl_if, fl_id, br_flush;

   fw_sel #(.SEL_W(SEL_W)) u_fw0 (
      .rs_addr_i      (ex_rs1_addr_i),
      .mem_valid_i    (mem_valid_i),
      .mem_regwrite_i (mem_regwrite_i),
      .mem_rd_addr_i  (mem_rd_addr_i),
      .mem_wb_sel_i   (mem_wb_sel_i),
      .wb_valid_i     (wb_valid_i),
      .wb_regwrite_i  (wb_regwrite_i),
      .wb_rd_addr_i   (wb_rd_addr_i),
      .wb_sel_i       (wb_sel_i),
      .sel_o          (sel0)
   );

   fw_sel #(.SEL_W(SEL_W)) u_fw1 (
      .rs_addr_i      (ex_rs2_addr_i),
      .mem_valid_i    (mem_valid_i),
      .mem_regwrite_i (mem_regwrite_i),
      .mem_rd_addr_i  (mem_rd_addr_i),
      .mem_wb_sel_i   (mem_wb_sel_i),
      .wb_valid_i     (wb_valid_i),
      .wb_regwrite_i  (wb_regwrite_i),
      .wb_rd_addr_i   (wb_rd_addr_i),
      .wb_sel_i       (wb_sel_i),
      .sel_o          (sel1)
   );

   assign lu_hazard = dec_valid_i && ex_valid_i && ex_regwrite_i
                      && (ex_rd_addr_i != 5'd0) && (ex_wb_sel_i != WB_ALU)
                      && ((ex_rd_addr_i == dec_rs1_addr_i)
                          || (ex_rd_addr_i == dec_rs2_addr_i));

   // MEMWAIT with busy low behaves as RUN, so release and a waiting branch share a cycle.
   always_comb begin
      state_d  = state_q;
      bub_d    = bub_q;
      st_if    = 1'b0;
      st_id    = 1'b0;
      st_ex    = 1'b0;
      st_mem   = 1'b0;
      fl_if    = 1'b0;
      fl_id    = 1'b0;
      br_flush = 1'b0;
      if (dmem_busy_i) begin
         {st_if, st_id, st_ex, st_mem} = 4'b1111;
         state_d = ST_MEMWAIT;
      end else if (bj_sig_i) begin
         fl_if    = 1'b1;
         fl_id    = 1'b1;
         br_flush = 1'b1;
         state_d  = ST_RUN;
      end else begin
         case (state_q)
            ST_BUBBLE: begin
               st_if = 1'b1;
               fl_id = 1'b1;
               if (bub_q <= 2'd1) state_d = ST_RUN;
               else               bub_d   = bub_q - 2'd1;
            end
            default: begin
               state_d = ST_RUN;
               if (lu_hazard) begin
                  st_if = 1'b1;
                  fl_id = 1'b1;
                  if (LU_STALL > 1) begin
                     state_d = ST_BUBBLE;
                     bub_d   = 2'(LU_STALL - 1);
                  end
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= ST_RUN;
         bub_q       <= '0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         state_q <= state_d;
         bub_q   <= bub_d;
         if ((st_if || st_id || st_ex || st_mem) && (stall_cnt_q != '1))
            stall_cnt_q <= stall_cnt_q + 1'b1;
         if (br_flush && (flush_cnt_q != '1))
            flush_cnt_q <= flush_cnt_q + 1'b1;
      end
   end

   assign stall_if_o  = rst_ni & st_if;
   assign stall_id_o  = rst_ni & st_id;
   assign stall_ex_o  = rst_ni & st_ex;
   assign stall_mem_o = rst_ni & st_mem;
   assign flush_if_o  = ~rst_ni | fl_if;
   assign flush_id_o  = ~rst_ni | fl_id;
   assign flush_ex_o  = ~rst_ni;
   assign flush_mem_o = ~rst_ni;
   assign fw0_sel_o   = rst_ni ? sel0 : SEL_W'(FW_RF);
   assign fw1_sel_o   = rst_ni ? sel1 : SEL_W'(FW_RF);
   assign stall_cnt_o = stall_cnt_q;
   assign flush_cnt_o = flush_cnt_q;

endmodule
